// File: rtl/priority_encoder.sv
// Registered 4-to-2 priority encoder with valid flag; D[0] is the highest priority.
// One cycle of latency from D to Y/valid, synchronous active-high reset.
module priority_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D,
    output logic [1:0] Y,
    output logic       valid
);

    localparam int unsigned REQ_W = 4;
    localparam int unsigned IDX_W = 2;

    logic [IDX_W-1:0] y_d;
    logic [IDX_W-1:0] y_q;
    logic             valid_d;
    logic             valid_q;
    logic [REQ_W-1:0] req;

    assign req = D;

    // Next-state encode: reset is checked first so X on D is never looked at.
    always_comb begin
        y_d     = '0;
        valid_d = 1'b0;
        if (!rst) begin
            if (req[0]) begin
                y_d     = IDX_W'(3);
                valid_d = 1'b1;
            end else if (req[1]) begin
                y_d     = IDX_W'(2);
                valid_d = 1'b1;
            end else if (req[2]) begin
                y_d     = IDX_W'(1);
                valid_d = 1'b1;
            end else if (req[3]) begin
                y_d     = IDX_W'(0);
                valid_d = 1'b1;
            end
        end
    end

    // Output registers; reset is folded into the next-state logic.
    always_ff @(posedge clk) begin
        y_q     <= y_d;
        valid_q <= valid_d;
    end

    assign Y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder: directed sweeps plus random traffic
// checked against a lowest-set-bit reference model.
module tb_priority_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D;
    logic [1:0] Y;
    logic       valid;

    int   tests = 0;
    int   fails = 0;
    logic [2:0] exp_q;
    logic       have_exp = 1'b0;

    priority_encoder dut (
        .clk   (clk),
        .rst   (rst),
        .D     (D),
        .Y     (Y),
        .valid (valid)
    );

    always #5 clk = ~clk;

    // Reference: Y = 3 - index of the lowest set bit, valid if any bit set.
    function automatic logic [2:0] ref_model(input logic r, input logic [3:0] d);
        if (r === 1'b1) return 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (d[i] === 1'b1) return {2'(3 - i), 1'b1};
        end
        return 3'b000;
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed={Y,valid}=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Drive just after a rising edge, confirm outputs hold, then check after the next edge.
    task automatic step(input string tag, input logic r, input logic [3:0] d);
        rst = r;
        D   = d;
        #2;
        if (have_exp) check({tag, "_hold"}, {Y, valid}, exp_q);
        @(posedge clk);
        #1;
        exp_q    = ref_model(r, d);
        have_exp = 1'b1;
        check(tag, {Y, valid}, exp_q);
    endtask

    initial begin
        rst = 1'b1;
        D   = 4'bxxxx;
        @(posedge clk);
        #1;

        // Reset sweep, including undriven D
        step("rst_x", 1'b1, 4'bxxxx);
        for (int i = 0; i < 16; i++) step("rst_sweep", 1'b1, 4'(i));
        check("rst_const", {Y, valid}, 3'b000);

        // Functional sweep
        for (int i = 0; i < 16; i++) step("func_sweep", 1'b0, 4'(i));

        // Priority overlap
        step("ovl_1111", 1'b0, 4'b1111);
        check("ovl_1111_abs", {Y, valid}, 3'b111);
        step("ovl_1110", 1'b0, 4'b1110);
        check("ovl_1110_abs", {Y, valid}, 3'b101);
        step("ovl_1100", 1'b0, 4'b1100);
        check("ovl_1100_abs", {Y, valid}, 3'b011);

        // Latency: 1000 then 0001 driven just after the edge
        step("lat_1000", 1'b0, 4'b1000);
        check("lat_1000_abs", {Y, valid}, 3'b001);
        step("lat_0001", 1'b0, 4'b0001);
        check("lat_0001_abs", {Y, valid}, 3'b111);

        // Reset mid-operation and release
        step("mid_rst", 1'b1, 4'b0001);
        check("mid_rst_abs", {Y, valid}, 3'b000);
        step("rst_rel", 1'b0, 4'b0001);
        check("rst_rel_abs", {Y, valid}, 3'b111);

        // Idle after activity
        step("idle_0100", 1'b0, 4'b0100);
        check("idle_0100_abs", {Y, valid}, 3'b011);
        step("idle_0000", 1'b0, 4'b0000);
        check("idle_0000_abs", {Y, valid}, 3'b000);

        // Random back-to-back traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(7) == 0), 4'($urandom_range(15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/priority_encoder.md
# priority_encoder

Registered 4-to-2 priority encoder with a valid flag. D[0] has the highest priority and D[3] the lowest. The block encodes a 4-bit request vector into a 2-bit index of the winning request, registered on the rising clock edge. It is a standalone arbitration/encoding primitive used wherever a one-cycle-latency request index is needed.

## Interface

Parameters:
- None. Widths are fixed: 4-bit input, 2-bit index.

Ports:
- clk   input   1   rising-edge clock for all state.
- rst   input   1   reset, synchronous, active-high.
- D     input   4   request vector. D[0] has highest priority, D[3] lowest.
- Y     output  2   registered encoded index of the winning request.
- valid output  1   registered flag; 1 when at least one request bit was set.

## Operation

- Y and valid are flops updated only on the rising edge of clk.
- Reset, when rst=1 at a rising edge:
  - Y <= 2'b00 and valid <= 0.
  - D is ignored, including X/undriven values.
- Normal encode, when rst=0 at a rising edge, using the D sampled at that edge:
  - D[0]=1 -> Y=2'b11, valid=1. Other bits are ignored.
  - else D[1]=1 -> Y=2'b10, valid=1.
  - else D[2]=1 -> Y=2'b01, valid=1.
  - else D[3]=1 -> Y=2'b00, valid=1.
  - D=4'b0000 -> Y=2'b00, valid=0.
- Encoding rule: Y = 3 − (index of the lowest set bit). The combined value {Y,valid} is 3'b111, 3'b101, 3'b011, 3'b001 or 3'b000 for the five cases above.
- No internal state other than the two output registers. No handshake. Every edge overwrites the outputs.

## Timing

- Latency is 1 cycle: D sampled at rising edge N is reflected on Y/valid immediately after edge N. Outputs are stable for sampling at the following falling edge.
- Outputs are glitch-free: they change only on rising clk edges.
- Reset asserted mid-stream: outputs go to 0/0 at the first rising edge with rst=1. Before that edge they hold the previous value, because reset is synchronous.
- Reset deassertion: the first rising edge with rst=0 encodes the D present at that edge. No extra dead cycles.
- Power-up before the first reset edge: output values are undefined. Consumers must apply rst for at least 1 cycle.
- Simultaneous multiple request bits: only the lowest-indexed set bit determines Y. valid=1.
- Back-to-back input changes every cycle are fully supported. Each edge's output depends only on that edge's D and rst.

## Test plan

- Reset sweep: rst=1, D cycled 0..15 (one value per cycle) -> Y=2'b00, valid=0 after every edge.
- Full functional sweep: rst=0, D cycled 0..15 with checks at each falling edge:
  - odd D -> {Y,valid}=3'b111.
  - D in {2,6,10,14} -> 3'b101.
  - D in {4,12} -> 3'b011.
  - D=8 -> 3'b001.
  - D=0 -> valid=0, Y=2'b00.
- Priority overlap: D=4'b1111 -> Y=2'b11; D=4'b1110 -> Y=2'b10; D=4'b1100 -> Y=2'b01. valid=1 in all three cases.
- Latency check: change D from 4'b1000 to 4'b0001 just after a rising edge -> Y stays 2'b00 until the next rising edge, then becomes 2'b11.
- Reset mid-operation: D=4'b0001 with valid=1, then assert rst for one cycle -> Y=2'b00, valid=0 after that edge. Deassert rst -> Y=2'b11, valid=1 after the next edge.
- Idle after activity: D=4'b0100, then D=4'b0000 -> valid falls to 0 and Y=2'b00 one cycle after D clears.
